// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and a saturating count of flushed entries.
module pipe_skid_reg #(
  parameter int DATA_W           = 128,
  parameter int CTRL_W           = 16,
  parameter int SKID             = 1,
  parameter int BUBBLE_DATA_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [1:0]        occupancy,
  output logic [7:0]        drop_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t     state_q, state_d;
  entry_t     main_q, main_d, skid_q, skid_d, up_ent;
  logic [7:0] drop_q, drop_d;
  logic [8:0] drop_sum;
  logic       up_fire, dn_fire;

  assign up_ent   = {up_ctrl, up_data};
  assign dn_valid = (state_q != EMPTY);

  generate
    if (SKID != 0) begin : g_skid
      assign up_ready = (state_q != FULL) & ~flush;
    end else begin : g_noskid
      assign up_ready = (~dn_valid | dn_ready) & ~flush;
    end
  endgenerate

  assign up_fire = up_valid & up_ready;
  // Flush wins: a downstream accept in the flush cycle does not move state.
  assign dn_fire = dn_valid & dn_ready & ~flush;

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    drop_d   = drop_q;
    drop_sum = {1'b0, drop_q} + {7'd0, state_q};
    if (flush) begin
      state_d = EMPTY;
      drop_d  = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end else begin
      case (state_q)
        EMPTY: if (up_fire) begin
          state_d = ONE;
          main_d  = up_ent;
        end
        ONE: begin
          if (up_fire && dn_fire) begin
            main_d = up_ent;
          end else if (up_fire && SKID != 0) begin
            state_d = FULL;
            skid_d  = up_ent;
          end else if (dn_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: if (dn_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      drop_q  <= drop_d;
    end
  end

  assign occupancy = state_q;
  assign drop_cnt  = drop_q;
  assign dn_ctrl   = dn_valid ? main_q.ctrl : '0;
  assign dn_data   = (!dn_valid && BUBBLE_DATA_ZERO != 0) ? '0 : main_q.data;

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register with a valid/ready handshake. It replaces fixed-field stage registers such as the ID/EX latch and carries any stage boundary as one DATA_W payload plus one CTRL_W control field. On a stall it holds the instruction instead of bubbling it, so the stage does not rely on the upstream stage to replay. An optional two-entry skid buffer breaks the combinational ready path. A flush kills every held entry and counts the drops for debug.

## Interface
- DATA_W, 128, width of the data payload (operands, immediate, PC+4, register indices).
- CTRL_W, 16, width of the control field (ALU op, memory read/write, register write, branch/jump/link bits); all-zero means NOP.
- SKID, 1, 1 = two-entry skid buffer with registered up_ready; 0 = single entry with combinational up_ready.
- BUBBLE_DATA_ZERO, 1, 1 = dn_data reads zero whenever dn_valid=0; 0 = dn_data holds its last value.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous kill of all held entries; overrides any handshake in the same cycle.
- up_valid  in  1  upstream has an entry.
- up_ready  out  1  block accepts an entry this cycle.
- up_data  in  DATA_W  upstream payload.
- up_ctrl  in  CTRL_W  upstream control field.
- dn_valid  out  1  an entry is presented downstream.
- dn_ready  in  1  downstream accepts the entry this cycle.
- dn_data  out  DATA_W  presented payload.
- dn_ctrl  out  CTRL_W  presented control field; all-zero whenever dn_valid=0.
- occupancy  out  2  number of held entries (0..2; never exceeds 1 when SKID=0).
- drop_cnt  out  8  saturating count of entries discarded by flush.

## Operation
- Handshake terms: up_fire = up_valid & up_ready; dn_fire = dn_valid & dn_ready. Entries leave in arrival order.
- Storage: main register drives dn_*; skid register (SKID=1 only) catches an entry that arrives while main is stalled.
- States, encoded by occupancy:
  - EMPTY. up_fire goes to ONE with main <= up.
  - ONE, when up_fire & dn_fire: stay in ONE with main <= up.
  - ONE, when up_fire & !dn_fire: go to FULL with skid <= up. This transition is only reachable with SKID=1.
  - ONE, when !up_fire & dn_fire: go to EMPTY.
  - ONE, otherwise: hold.
  - FULL: up_ready=0. dn_fire goes to ONE with main <= skid; otherwise hold.
- up_ready:
  - SKID=1: up_ready = (occupancy != 2) & !flush. It is registered state plus flush only, with no path from dn_ready.
  - SKID=0: up_ready = (!dn_valid | dn_ready) & !flush.
- Stall is expressed by dn_ready=0. The held entry stays stable on dn_* until it is accepted.
- Flush:
  - occupancy <= 0 and dn_valid <= 0.
  - Any entry offered on up_* in that cycle is not accepted, because up_ready=0.
  - drop_cnt <= min(255, drop_cnt + occupancy).
- Bubble guarantee:
  - dn_ctrl is forced to zero whenever dn_valid=0.
  - dn_data is forced to zero when dn_valid=0 only if BUBBLE_DATA_ZERO=1.
- Reset values:
  - dn_valid=0, dn_data=0, dn_ctrl=0, occupancy=0, drop_cnt=0.
  - up_ready=1 once reset is low, provided flush is low.
  - Skid contents are cleared.

## Timing
- Latency: an entry accepted on edge N appears on dn_* after edge N, so it is visible in cycle N+1.
- Throughput: one entry per cycle while dn_ready=1, in both SKID modes.
- SKID=1: up_ready drops one cycle after FULL is entered. The entry accepted in the cycle the stall began is captured in skid, so no entry is lost or duplicated.
- Simultaneous flush with up_fire or dn_fire: flush wins. No downstream transfer is counted as accepted for state purposes, and the entry is counted as dropped.
- Reset asserted mid-operation clears state asynchronously without waiting for clk. drop_cnt is not incremented by reset.
- drop_cnt saturates at 255 and never wraps.

## Test plan
- Streaming:
  - Stimulus: dn_ready=1, 8 entries with up_data=1..8 and up_ctrl=16'h0001 on consecutive cycles.
  - Required: dn_data=1..8 starting one cycle later, no gaps, occupancy ≤1.
- Stall capture, SKID=1:
  - Stimulus: entries A=0xA, B=0xB, C=0xC; dn_ready falls the cycle B is accepted.
  - Required: occupancy=2, up_ready=0, C held upstream. Releasing dn_ready yields A, B, C in order with no duplication.
- Flush while full:
  - Stimulus: with occupancy=2, assert flush for 1 cycle while up_valid=1.
  - Required: next cycle dn_valid=0, dn_ctrl=0, dn_data=0, occupancy=0, drop_cnt=2, and the offered entry is not accepted.
- Counter saturation:
  - Stimulus: 130 flushes with occupancy=2.
  - Required: drop_cnt=255 and it stays at 255.
- SKID=0 mode:
  - Stimulus: dn_ready toggling 1,0,1.
  - Required: up_ready equals !dn_valid | dn_ready in the same cycle, and occupancy never reaches 2.
- Async reset mid-stall:
  - Stimulus: assert reset between clock edges with occupancy=2.
  - Required: dn_valid, occupancy and drop_cnt are 0 immediately. After release, up_ready=1 and the first new entry appears one cycle after acceptance.
